// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT wait states, byte-enabled stores,
// single-cycle response pulse and a saturating committed-store counter.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT        = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err,
  output logic [15:0] store_count
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] count_q, count_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          acc_we;
  logic [31:0]   acc_addr, acc_wdata;
  logic [3:0]    acc_be;
  logic [AW-1:0] acc_idx;
  logic          acc_err, do_access, mem_we;

  // With WAIT=0 the access happens on the acceptance edge, before the latches hold the request.
  always_comb begin
    if (state_q == StIdle) begin
      acc_we    = we;
      acc_addr  = addr;
      acc_wdata = wdata;
      acc_be    = be;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
    acc_idx = acc_addr[AW+1:2];
    acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:AW+2] != '0);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    do_access = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          cnt_d = 4'(WAIT);
          if (WAIT == 0) begin
            state_d   = StResp;
            do_access = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q <= 4'd1) begin
          state_d   = StResp;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    err_d   = err_q;
    rdata_d = rdata_q;
    count_d = count_q;
    mem_we  = do_access && acc_we && !acc_err;
    if (do_access) begin
      err_d = acc_err;
      if (!acc_err) begin
        if (acc_we) begin
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
        end else begin
          rdata_d = mem[acc_idx];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        be_q    <= be;
      end
      err_q   <= err_d;
      rdata_q <= rdata_d;
      count_q <= count_d;
    end
  end

  // Array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign ready       = (state_q == StIdle);
  assign rvalid      = (state_q == StResp);
  assign err         = rvalid && err_q;
  assign rdata       = rdata_q;
  assign store_count = count_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle/multicycle CPU core: the target side of the core's store/load port (address, write data, write strobe). It accepts one request at a time through a req/ready handshake, inserts a programmable number of wait states, commits stores with byte enables, and returns load data or a store acknowledge through a one-cycle response pulse. It also counts committed stores so the system bench can check store activity without probing the array.

## Interface

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words; power of two, minimum 4.
- WAIT, 1, wait states between acceptance and response; range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- req  input  1  request valid.
- we  input  1  1 = store, 0 = load; sampled with req.
- addr  input  32  byte address; sampled with req.
- wdata  input  32  store data; sampled with req.
- be  input  4  byte enables, be[i] selects wdata[8i+7:8i]; store only.
- ready  output  1  responder can accept a request this cycle.
- rvalid  output  1  one-cycle response pulse, for both loads and stores.
- rdata  output  32  load data; meaningful only while rvalid=1 and err=0.
- err  output  1  error flag, qualified by rvalid.
- store_count  output  16  committed-store counter, saturating at 16'hFFFF.

## Operation

- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - ready=1.
  - If req=1, latch we, addr, wdata and be.
  - Load the wait counter with WAIT.
  - Go to WAIT if WAIT>0, else go to RESP.
- WAIT:
  - ready=0; the counter decrements each cycle.
  - When the counter reaches 1, go to RESP.
  - WAIT therefore lasts exactly WAIT cycles.
- RESP:
  - ready=0, rvalid=1 for exactly one cycle; then return to IDLE.
- Access is performed at the clock edge that enters RESP:
  - Store: for each be[i]=1, write the byte into mem[addr[log2(DEPTH_WORDS)+1:2]]. Bytes with be[i]=0 are unchanged.
  - Load: rdata gets the full word; be is ignored.
- Error conditions:
  - addr[1:0] != 0, or addr >= 4*DEPTH_WORDS, gives err=1 in RESP.
  - On error, there is no array write, store_count is unchanged, and rdata holds its previous value.
- store_count increments by 1 on each non-error store, including be=4'b0000, and saturates.
- rdata holds its last load value outside load responses.
- Memory array is not reset; its contents are undefined until written.
- req is ignored while ready=0; the requester must hold or re-present it.

## Timing

- Reset (asynchronous, any state):
  - FSM goes to IDLE; ready=1, rvalid=0, err=0, rdata=0, store_count=0.
- Reset mid-operation: a pending request is discarded; its store is not committed and no response is issued.
- Acceptance edge: the rising edge with req=1 and ready=1.
- Latency: rvalid is asserted in cycle WAIT+1 after the acceptance edge.
  - WAIT=0: rvalid is high the cycle after acceptance.
  - WAIT=3: rvalid is high in the 4th cycle.
- Throughput: one access per WAIT+2 cycles. ready returns to 1 the cycle after rvalid.
- Read-after-write to the same word returns the newly written data. The store commits before a later load is sampled.
- A store or load to the last word (addr = 4*DEPTH_WORDS-4) is legal. The next word boundary raises err.
- store_count at 16'hFFFF stays 16'hFFFF on further stores.

## Test plan

- WAIT=1, store addr=100 wdata=25 be=4'hF, then load addr=100:
  - Store response: rvalid in cycle 2 after acceptance, err=0, store_count=1.
  - Load response: rdata=25, err=0.
- Byte enables: store 32'hAABBCCDD be=4'hF to addr 8, then store 32'h11223344 be=4'b0101 to addr 8, then load addr 8 -> rdata=32'hAA22CC44; store_count=2.
- Errors with DEPTH_WORDS=64:
  - Load addr=256 -> rvalid=1, err=1.
  - Store addr=102 -> err=1, and a subsequent load of addr 100 returns the prior word unchanged.
  - store_count is unchanged by both.
- Latency sweep with WAIT=0 and WAIT=3 on back-to-back requests:
  - rvalid arrives 1 and 4 cycles after acceptance respectively.
  - ready is low from the acceptance edge until the cycle after rvalid.
- Reset mid-operation, WAIT=3:
  - Accept store addr=100 wdata=7, assert rst asynchronously during WAIT.
  - Outputs go to reset values immediately, no rvalid follows, store_count=0.
  - A later load of addr 100 returns the pre-reset contents, not 7.
- Saturation: force 65536 stores -> store_count stays 16'hFFFF after the 65535th store.
